conv1_controller: RTL and testbench
===================================

# conv1_controller

Sequences one conv1 layer pass through a single conv1 processing element: walks all output channels and positions, fetches two input samples plus two weights and a bias per output, streams them into the PE one per cycle, and writes the quantised results into the output feature buffer. Sits between the input, weight and bias buffers and the PE, under the layer-level top that pulses `start`.

## Interface
- `IN_LEN`, 64: input samples per job; must be at least 2.
- `OUT_CH`, 8: output channels.
- `STRIDE`, 1: input step between outputs; must be at least 1.
- Derived: `OUT_LEN = (IN_LEN-2)/STRIDE + 1` and `N = OUT_CH*OUT_LEN`.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last output write.
- `x_addr`  out  clog2(IN_LEN)  input buffer address; the buffer returns samples [a] and [a+1].
- `x_rd0`, `x_rd1`  in  16 signed  samples, returned 1 cycle after the address.
- `w_addr`  out  clog2(OUT_CH)  weight and bias address (channel).
- `w_rd0`, `w_rd1`  in  16 signed  weights, 1-cycle read latency.
- `b_rd`  in  32 signed  bias, 1-cycle read latency.
- `pe_rst`  out  1  active-high clear to the PE.
- `pe_start`  out  1  PE start.
- `pe_x0`, `pe_x1`, `pe_w0`, `pe_w1`  out  16 signed  registered PE operands.
- `pe_b`  out  32 signed  registered PE bias.
- `pe_odata`  in  16 signed  PE result.
- `out_we`  out  1  output buffer write enable.
- `out_addr`  out  clog2(N)  output address, `c*OUT_LEN + p`.
- `out_data`  out  16 signed  output value.

## Operation
- FSM states: IDLE, CLR, RUN, DRAIN, FIN.
- IDLE to CLR: on `start`.
- CLR: one cycle with `pe_rst=1`, then RUN. The PE's internal stage enables latch and never clear, so the controller clears them at the start of every job and never relies on PE `done`.
- RUN: issues one element per cycle, `x_addr = p*STRIDE` and `w_addr = c`.
  - `p` runs from 0 to OUT_LEN-1. When `p` wraps to 0, `c` increments.
  - After element `N-1` is issued, go to DRAIN.
- DRAIN: wait until the valid delay line is empty, then FIN.
- FIN: pulse `done=1` for one cycle, `busy=0` from the next cycle, return to IDLE.
- Operands are registered from the buffer read data. `pe_start` is held high for the whole RUN and DRAIN window, because the PE runs every cycle once started.
- A 7-deep valid/address delay line marks which PE output cycles carry real results. `out_we` is asserted only for valid slots.
- `out_data` is `pe_odata` registered unchanged. ReLU and the /1000 quantisation live in the PE.
- `start` while not in IDLE is ignored.
- Reset (`rst=0`), including mid-job:
  - next edge returns to IDLE and clears counters and the delay line;
  - all outputs are 0 except `pe_rst`, which is 1 for as long as `rst=0`.
  - No partial job resumes.

## Timing
- Element issued in cycle k (address on the bus):
  - read data arrives in k+1;
  - `pe_start` with operands in k+2;
  - `pe_odata` is valid in k+6;
  - `out_we` with `out_addr`/`out_data` in k+7.
- Throughput is one output per cycle.
- Job length: `start` in cycle 0, CLR in cycle 1, issues in cycles 2 to N+1, last write in N+8, `done` in N+9.
- Outputs reset to 0; `pe_rst` resets to 1.
- `start` in the same cycle that `done` is high is ignored; the earliest accepted restart is the cycle after `done`.

## Structure
- A shared `conv1_pkg` holds the FSM state encoding, the latency constants (read latency 1, PE latency 4, total 7), and the `OUT_LEN`/`N` derivation.
- One sub-module, `conv1_valid_pipe`: a parameterised-depth shift register carrying valid and out_addr.

## Test plan
- IN_LEN=8, STRIDE=1, OUT_CH=2, all x=1000, w0=w1=1, b=0 -> 14 writes, addresses 0 to 13, every value 2, `done` in cycle 23.
- Same configuration with w0=w1=-1 -> 14 writes of 0 (ReLU), no extra or missing `out_we`.
- IN_LEN=9, STRIDE=2 -> `x_addr` sequence 0,2,4,6 per channel; OUT_LEN=4; channel 1 results written at addresses 4 to 7.
- `rst=0` at cycle 6 of a job -> `out_we` stays 0, `pe_rst=1` while reset is held, `busy=0`; a fresh `start` then completes with correct data.
- `start` pulsed during RUN and in the `done` cycle -> ignored, exactly one job's writes observed.
- Two back-to-back jobs (`start` the cycle after `done`) -> the second job's `pe_rst` pulse is observed and all results match the reference model.

Source files
------------

// File: rtl/conv1_pkg.sv
// Shared definitions for the conv1 controller: FSM encoding, pipeline latencies
// and the output geometry derived from the layer parameters.
package conv1_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int RD_LAT    = 1;
  localparam int PE_LAT    = 4;
  // Buffer read, operand register, PE pipeline, output register.
  localparam int TOTAL_LAT = RD_LAT + 1 + PE_LAT + 1;

  function automatic int out_len(input int in_len, input int stride);
    return (in_len - 2) / stride + 1;
  endfunction

  function automatic int n_total(input int in_len, input int out_ch, input int stride);
    return out_ch * out_len(in_len, stride);
  endfunction

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/conv1_if.sv
// Bus bundle between conv1_controller and the job control, the input/weight/bias
// buffers, the PE and the output feature buffer.
interface conv1_if
  import conv1_pkg::*;
#(
  parameter int IN_LEN = 64,
  parameter int OUT_CH = 8,
  parameter int STRIDE = 1
);
  localparam int XAW = addr_w(IN_LEN);
  localparam int WAW = addr_w(OUT_CH);
  localparam int OAW = addr_w(n_total(IN_LEN, OUT_CH, STRIDE));

  logic               start;
  logic               busy;
  logic               done;
  logic [XAW-1:0]     x_addr;
  logic signed [15:0] x_rd0;
  logic signed [15:0] x_rd1;
  logic [WAW-1:0]     w_addr;
  logic signed [15:0] w_rd0;
  logic signed [15:0] w_rd1;
  logic signed [31:0] b_rd;
  logic               pe_rst;
  logic               pe_start;
  logic signed [15:0] pe_x0;
  logic signed [15:0] pe_x1;
  logic signed [15:0] pe_w0;
  logic signed [15:0] pe_w1;
  logic signed [31:0] pe_b;
  logic signed [15:0] pe_odata;
  logic               out_we;
  logic [OAW-1:0]     out_addr;
  logic signed [15:0] out_data;

  modport master (
    input  start, x_rd0, x_rd1, w_rd0, w_rd1, b_rd, pe_odata,
    output busy, done, x_addr, w_addr, pe_rst, pe_start,
           pe_x0, pe_x1, pe_w0, pe_w1, pe_b, out_we, out_addr, out_data
  );

  modport slave (
    output start, x_rd0, x_rd1, w_rd0, w_rd1, b_rd, pe_odata,
    input  busy, done, x_addr, w_addr, pe_rst, pe_start,
           pe_x0, pe_x1, pe_w0, pe_w1, pe_b, out_we, out_addr, out_data
  );

endinterface

// File: rtl/conv1_valid_pipe.sv
// Shift register that carries an issue-valid flag and its output address
// alongside the data path so the result write lines up with the PE output.
module conv1_valid_pipe #(
  parameter int DEPTH = 7,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          pending
);
  logic [DEPTH-1:0] vld_r;
  logic [AW-1:0]    addr_r [DEPTH];

  // Shift valid and address one stage per cycle; reset empties the line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_r <= '0;
      for (int i = 0; i < DEPTH; i++) addr_r[i] <= '0;
    end else begin
      vld_r     <= {vld_r[DEPTH-2:0], in_valid};
      addr_r[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) addr_r[i] <= addr_r[i-1];
    end
  end

  assign out_valid = vld_r[DEPTH-1];
  assign out_addr  = addr_r[DEPTH-1];
  // The last stage is being written this cycle, so it no longer counts as in flight.
  assign pending   = |vld_r[DEPTH-2:0];

endmodule

// File: rtl/conv1_controller.sv
// Sequences one conv1 layer pass through a single PE: issues one output element
// per cycle, streams its operands into the PE and writes the results back.
module conv1_controller
  import conv1_pkg::*;
#(
  parameter int IN_LEN = 64,
  parameter int OUT_CH = 8,
  parameter int STRIDE = 1
) (
  input  logic     clk,
  input  logic     rst,
  conv1_if.master  bus
);
  localparam int OUT_LEN = out_len(IN_LEN, STRIDE);
  localparam int N       = n_total(IN_LEN, OUT_CH, STRIDE);
  localparam int XAW     = addr_w(IN_LEN);
  localparam int WAW     = addr_w(OUT_CH);
  localparam int OAW     = addr_w(N);
  localparam int PW      = addr_w(OUT_LEN);

  state_t             state_r, next_s;
  logic [PW-1:0]      p_r;
  logic [WAW-1:0]     c_r;
  logic [XAW-1:0]     xa_r;
  logic [OAW-1:0]     o_r;
  logic               all_issued_r;
  logic               issue_s, p_wrap_s, last_s, pend_s;
  logic               issue_vld_r;
  logic [XAW-1:0]     x_addr_r;
  logic [WAW-1:0]     w_addr_r;
  logic [OAW-1:0]     issue_addr_r;
  logic               busy_r, done_r, pe_rst_r, pe_start_r;
  logic signed [15:0] pe_x0_r, pe_x1_r, pe_w0_r, pe_w1_r, out_data_r;
  logic signed [31:0] pe_b_r;
  logic               out_we_s;
  logic [OAW-1:0]     out_addr_s;

  assign p_wrap_s = (p_r == PW'(OUT_LEN - 1));
  assign last_s   = (o_r == OAW'(N - 1));

  // Next-state logic; CLR issues element 0 so RUN starts with the bus already loaded.
  always_comb begin
    next_s  = state_r;
    issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) next_s = CLR;
        else           next_s = IDLE;
      end
      CLR: begin
        issue_s = 1'b1;
        next_s  = RUN;
      end
      RUN: begin
        if (all_issued_r) begin
          next_s = DRAIN;
        end else begin
          issue_s = 1'b1;
          next_s  = RUN;
        end
      end
      DRAIN: begin
        if (pend_s || issue_vld_r) next_s = DRAIN;
        else                       next_s = FIN;
      end
      FIN:     next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register and the control outputs derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pe_rst_r   <= 1'b1;
      pe_start_r <= 1'b0;
    end else begin
      state_r    <= next_s;
      busy_r     <= (next_s != IDLE);
      done_r     <= (next_s == FIN);
      pe_rst_r   <= (next_s == CLR);
      pe_start_r <= (next_s == RUN) || (next_s == DRAIN);
    end
  end

  // Position/channel walk; counters point at the next element to issue.
  always_ff @(posedge clk) begin
    if (!rst || state_r == IDLE) begin
      p_r          <= '0;
      c_r          <= '0;
      xa_r         <= '0;
      o_r          <= '0;
      all_issued_r <= 1'b0;
    end else if (issue_s) begin
      if (last_s) begin
        all_issued_r <= 1'b1;
      end else begin
        o_r <= o_r + OAW'(1);
        if (p_wrap_s) begin
          p_r  <= '0;
          xa_r <= '0;
          c_r  <= c_r + WAW'(1);
        end else begin
          p_r  <= p_r + PW'(1);
          xa_r <= xa_r + XAW'(STRIDE);
        end
      end
    end
  end

  // Buffer addresses for the element being issued, plus its valid tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_vld_r  <= 1'b0;
      x_addr_r     <= '0;
      w_addr_r     <= '0;
      issue_addr_r <= '0;
    end else begin
      issue_vld_r <= issue_s;
      if (issue_s) begin
        x_addr_r     <= xa_r;
        w_addr_r     <= c_r;
        issue_addr_r <= o_r;
      end
    end
  end

  // Operand and result registers; the PE and output buffer see flop outputs only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pe_x0_r    <= '0;
      pe_x1_r    <= '0;
      pe_w0_r    <= '0;
      pe_w1_r    <= '0;
      pe_b_r     <= '0;
      out_data_r <= '0;
    end else begin
      pe_x0_r    <= bus.x_rd0;
      pe_x1_r    <= bus.x_rd1;
      pe_w0_r    <= bus.w_rd0;
      pe_w1_r    <= bus.w_rd1;
      pe_b_r     <= bus.b_rd;
      out_data_r <= bus.pe_odata;
    end
  end

  conv1_valid_pipe #(
    .DEPTH (TOTAL_LAT),
    .AW    (OAW)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_vld_r),
    .in_addr   (issue_addr_r),
    .out_valid (out_we_s),
    .out_addr  (out_addr_s),
    .pending   (pend_s)
  );

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.x_addr   = x_addr_r;
  assign bus.w_addr   = w_addr_r;
  assign bus.pe_rst   = pe_rst_r;
  assign bus.pe_start = pe_start_r;
  assign bus.pe_x0    = pe_x0_r;
  assign bus.pe_x1    = pe_x1_r;
  assign bus.pe_w0    = pe_w0_r;
  assign bus.pe_w1    = pe_w1_r;
  assign bus.pe_b     = pe_b_r;
  assign bus.out_we   = out_we_s;
  assign bus.out_addr = out_addr_s;
  assign bus.out_data = out_data_r;

endmodule

// File: tb/tb_conv1_controller.sv
// Bench for conv1_controller: two configurations (8/1 and 9/2), buffer and PE
// models, and a scoreboard that matches every output write against expectations.
module tb_conv1_controller;
  import conv1_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_v [2];
  logic busy_v [2], done_v [2], pe_rst_v [2], we_v [2];
  logic [7:0] x_addr_v [2], w_addr_v [2], out_addr_v [2];
  logic signed [15:0] out_data_v [2];

  logic signed [15:0] x_mem  [2][16];
  logic signed [15:0] w0_mem [2][2];
  logic signed [15:0] w1_mem [2][2];
  logic signed [31:0] b_mem  [2][2];

  typedef struct { int inst; int addr; int data; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic signed [15:0] pe_fn(input logic signed [15:0] x0, input logic signed [15:0] x1,
                                               input logic signed [15:0] w0, input logic signed [15:0] w1,
                                               input logic signed [31:0] b);
    int s;
    s = int'(x0) * int'(w0) + int'(x1) * int'(w1) + int'(b);
    if (s < 0) s = 0;
    return 16'(s / 1000);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : h
    localparam int INL = (g == 0) ? 8 : 9;
    localparam int STR = (g == 0) ? 1 : 2;
    logic signed [15:0] pe_pipe [4];

    conv1_if #(.IN_LEN(INL), .OUT_CH(2), .STRIDE(STR)) bus ();
    conv1_controller #(.IN_LEN(INL), .OUT_CH(2), .STRIDE(STR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.start = start_v[g];
    always @(posedge clk) begin
      bus.x_rd0 <= x_mem[g][int'(bus.x_addr)];
      bus.x_rd1 <= x_mem[g][int'(bus.x_addr) + 1];
      bus.w_rd0 <= w0_mem[g][int'(bus.w_addr)];
      bus.w_rd1 <= w1_mem[g][int'(bus.w_addr)];
      bus.b_rd  <= b_mem[g][int'(bus.w_addr)];
    end

    // PE model: four-cycle pipeline with latched stages cleared by pe_rst.
    always @(posedge clk) begin
      if (bus.pe_rst) begin
        for (int i = 0; i < 4; i++) pe_pipe[i] <= '0;
      end else begin
        pe_pipe[0] <= pe_fn(bus.pe_x0, bus.pe_x1, bus.pe_w0, bus.pe_w1, bus.pe_b);
        for (int i = 1; i < 4; i++) pe_pipe[i] <= pe_pipe[i-1];
      end
    end
    assign bus.pe_odata = pe_pipe[3];

    assign busy_v[g]     = bus.busy;
    assign done_v[g]     = bus.done;
    assign pe_rst_v[g]   = bus.pe_rst;
    assign we_v[g]       = bus.out_we;
    assign x_addr_v[g]   = 8'(bus.x_addr);
    assign w_addr_v[g]   = 8'(bus.w_addr);
    assign out_addr_v[g] = 8'(bus.out_addr);
    assign out_data_v[g] = bus.out_data;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every write must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (we_v[i]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", int'(we_v[i]), 0);
          end else begin
            e = exp_q.pop_front();
            check("write_inst", i, e.inst);
            check("write_addr", int'(out_addr_v[i]), e.addr);
            check("write_data", int'(out_data_v[i]), e.data);
          end
        end
      end
    end
  end

  task automatic push_const(input int i, input int n, input int val);
    for (int k = 0; k < n; k++) exp_q.push_back('{inst: i, addr: k, data: val});
  endtask

  task automatic push_model(input int i);
    int ol = (i == 0) ? 7 : 4;
    int s  = (i == 0) ? 1 : 2;
    for (int c = 0; c < 2; c++)
      for (int p = 0; p < ol; p++)
        exp_q.push_back('{inst: i, addr: c * ol + p,
                          data: int'(pe_fn(x_mem[i][p*s], x_mem[i][p*s+1],
                                           w0_mem[i][c], w1_mem[i][c], b_mem[i][c]))});
  endtask

  task automatic run_job(input int i, input bit inject, input bit chain);
    int ol = (i == 0) ? 7 : 4;
    int s  = (i == 0) ? 1 : 2;
    int n  = 2 * ol;
    @(posedge clk); #1 start_v[i] = 1'b1;
    @(negedge clk);
    check("busy_cycle0", int'(busy_v[i]), 0);
    @(posedge clk); #1 start_v[i] = 1'b0;
    for (int cyc = 1; cyc <= n + 9; cyc++) begin
      @(negedge clk);
      check("busy", int'(busy_v[i]), 1);
      check("done", int'(done_v[i]), (cyc == n + 9) ? 1 : 0);
      check("pe_rst", int'(pe_rst_v[i]), (cyc == 1) ? 1 : 0);
      if (cyc >= 2 && cyc <= n + 1) begin
        check("x_addr", int'(x_addr_v[i]), ((cyc - 2) % ol) * s);
        check("w_addr", int'(w_addr_v[i]), (cyc - 2) / ol);
      end
      if (inject) start_v[i] = (cyc == 4 || cyc == n + 9);
    end
    check("writes_outstanding", exp_q.size(), 0);
    if (!chain) begin
      @(negedge clk);
      start_v[i] = 1'b0;
      check("busy_after_done", int'(busy_v[i]), 0);
      check("done_after_done", int'(done_v[i]), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      x_mem[0][i] = 16'sd1000;
      x_mem[1][i] = 16'(i * 1000);
    end
    w0_mem[0] = '{16'sd1, 16'sd1};
    w1_mem[0] = '{16'sd1, 16'sd1};
    b_mem[0]  = '{32'sd0, 32'sd0};
    w0_mem[1] = '{16'sd1, 16'sd2};
    w1_mem[1] = '{16'sd1, -16'sd1};
    b_mem[1]  = '{32'sd0, 32'sd5000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_busy", int'(busy_v[i]), 0);
      check("reset_done", int'(done_v[i]), 0);
      check("reset_pe_rst", int'(pe_rst_v[i]), 1);
      check("reset_out_we", int'(we_v[i]), 0);
      check("reset_out_addr", int'(out_addr_v[i]), 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_pe_rst", int'(pe_rst_v[0]), 0);

    // All x=1000, unit weights: every output is 2.
    push_const(0, 14, 2);
    run_job(0, 1'b0, 1'b0);

    // Negative weights clip to 0; stray start pulses in RUN and in the done cycle.
    w0_mem[0] = '{-16'sd1, -16'sd1};
    w1_mem[0] = '{-16'sd1, -16'sd1};
    push_const(0, 14, 0);
    run_job(0, 1'b1, 1'b0);

    // Stride 2 over nine samples: ch0 -> 4p+1, ch1 -> 2p+4.
    begin
      int tbl [8] = '{1, 5, 9, 13, 4, 6, 8, 10};
      for (int k = 0; k < 8; k++) exp_q.push_back('{inst: 1, addr: k, data: tbl[k]});
    end
    run_job(1, 1'b0, 1'b0);

    // Reset in cycle 6 of a job: nothing may be written, then a clean rerun.
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("midreset_pe_rst", int'(pe_rst_v[0]), 1);
        check("midreset_busy", int'(busy_v[0]), 0);
        check("midreset_done", int'(done_v[0]), 0);
        check("midreset_out_we", int'(we_v[0]), 0);
        check("midreset_x_addr", int'(x_addr_v[0]), 0);
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_pe_rst", int'(pe_rst_v[0]), 0);
    check("post_reset_busy", int'(busy_v[0]), 0);

    for (int i = 0; i < 8; i++) x_mem[0][i] = 16'(i * 500 - 1500);
    w0_mem[0] = '{16'sd3, -16'sd2};
    w1_mem[0] = '{16'sd1, 16'sd4};
    b_mem[0]  = '{32'sd2500, -32'sd700};
    push_model(0);
    run_job(0, 1'b0, 1'b0);

    // Back-to-back jobs: second start in the cycle right after done.
    push_model(0);
    run_job(0, 1'b0, 1'b1);
    b_mem[0] = '{-32'sd3000, 32'sd9000};
    push_model(0);
    run_job(0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
